ramb_sp_param: RTL
==================

# ramb_sp_param

Parametrised single-port synchronous block RAM: the generalised successor of the fixed 4096×1 primitive. Width, depth, write mode and output reset value are parameters. A built-in clear sequencer can fill the whole array with a constant value. It sits directly behind any datapath that previously instantiated the fixed-width RAM primitives.

## Interface

Parameters:
- DATA_W, 1: data width in bits, 1..64.
- ADDR_W, 12: address width; depth is 2^ADDR_W words.
- WRITE_MODE, 0: DO behaviour on write. 0 = write-first, 1 = read-first, 2 = no-change.
- SRVAL, 0: DATA_W-bit value driven on DO by reset.
- INIT_FILL, 0: DATA_W-bit value for every word at time zero; also the value written by the clear sequencer.

Ports:
- CLK, input, 1: clock. All activity is on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: port enable. Gates reads and writes; does not gate RST.
- WE, input, 1: write enable. Qualified by EN.
- ADDR, input, ADDR_W: word address.
- DI, input, DATA_W: write data.
- CLR, input, 1: single-cycle request to start the clear sequence.
- DO, output, DATA_W: read data.
- BUSY, output, 1: high while the clear sequence runs.

## Operation

- FSM states: IDLE and CLEAR. Reset state is IDLE.
- Reset (RST=1 at an edge):
  - DO ← SRVAL; BUSY ← 0; state ← IDLE; clear counter ← 0.
  - Memory contents are untouched.
  - RST takes priority over EN, WE and CLR in the same cycle.
- IDLE, EN=1, WE=0: DO ← mem[ADDR].
- IDLE, EN=1, WE=1: mem[ADDR] ← DI. DO depends on WRITE_MODE:
  - 0: DO ← DI.
  - 1: DO ← old mem[ADDR].
  - 2: DO holds.
- IDLE, EN=0: no memory or DO change.
- Clear request: CLR=1 in IDLE moves the block to CLEAR.
  - If a user access is presented in the same cycle, that access completes normally in the same cycle.
- CLEAR state:
  - Each cycle writes INIT_FILL to mem[cnt], then cnt ← cnt+1.
  - cnt is ADDR_W bits wide and starts at 0.
  - After writing address 2^ADDR_W−1, state ← IDLE and cnt ← 0 (natural wrap).
  - EN, WE and CLR are ignored. DO holds its last value.
- RST during CLEAR aborts the sequence. Words already written keep INIT_FILL; the remaining words keep their prior contents.
- Out-of-range addresses cannot occur, since depth is exactly 2^ADDR_W.
- At time zero every word equals INIT_FILL.

## Timing

- Read latency: 1 cycle. DO reflects the access on the edge at which EN was sampled.
- BUSY goes high at the edge that samples CLR=1 in IDLE.
- CLEAR lasts exactly 2^ADDR_W cycles. BUSY falls at the edge that performs the last write.
- A user access is accepted at the first edge with BUSY=0.
- Total cycles from CLR sampled to BUSY=0: 2^ADDR_W.
- The memory array has no reset. Only DO, BUSY, the state and cnt are reset.

## Configuration

- RAMB_SP_OUTREG_EN:
  - Defined: adds a second output register stage. The first-stage register is internal; DO is driven from the second stage.
  - Read latency becomes 2 cycles.
  - The second stage loads from the first stage on every edge, regardless of EN.
  - RST loads SRVAL into both stages.
  - BUSY timing is unchanged.
- Undefined: single output register, latency 1, as described above.

## Test plan

Bench configuration: DATA_W=8, ADDR_W=4, SRVAL=8'hA5, INIT_FILL=8'h3C.

- Reset and init: RST=1 for one edge → DO=A5, BUSY=0. Then read addresses 0..15 → each returns 3C one cycle later (two cycles with RAMB_SP_OUTREG_EN).
- Write modes, at address 5 with prior value 3C: write DI=77.
  - WRITE_MODE=0 → DO=77.
  - WRITE_MODE=1 → DO=3C.
  - WRITE_MODE=2 → DO holds the previous value.
  - In all modes, a subsequent read → 77.
- Enable gating: EN=0, WE=1, DI=FF at address 2 → DO unchanged; a later read of address 2 → 3C.
- Clear, full sequence:
  - Write 11 to address 0 and 22 to address 15.
  - Pulse CLR together with a write of 99 to address 7.
  - BUSY stays high for exactly 16 cycles.
  - A write of EE to address 3 while BUSY=1 is ignored.
  - After the sequence, reads of addresses 0, 3, 7 and 15 all → 3C.
- Reset mid-clear:
  - Fill all 16 words with 55, then pulse CLR.
  - Assert RST on the 6th CLEAR cycle.
  - Result: BUSY=0 and DO=A5 after that edge; addresses 0..4 read 3C; addresses 5..15 read 55.
- Output register, with RAMB_SP_OUTREG_EN defined:
  - A read of address 5 (value 77) → DO=77 exactly 2 cycles after the read edge.
  - RST → DO=A5 on the next edge and stays A5 for the following edge.

Source files
------------

// File: rtl/ramb_sp_param.sv
// ramb_sp_param: parametrised single-port synchronous block RAM.
// It has a built-in clear sequencer that fills every word with INIT_FILL.
// Optional feature macro: RAMB_SP_OUTREG_EN adds a second output register
// stage, which gives a read latency of 2 cycles.
module ramb_sp_param #(
  parameter int unsigned       DATA_W     = 1,
  parameter int unsigned       ADDR_W     = 12,
  parameter int unsigned       WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] SRVAL      = '0,
  parameter logic [DATA_W-1:0] INIT_FILL  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic              CLR,
  output logic [DATA_W-1:0] DO,
  output logic              BUSY
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clearCnt_q, clearCnt_d;
  logic [DATA_W-1:0] doStage1_q, doStage1_d;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  // The array has no reset. Every word powers up holding INIT_FILL.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_FILL};

  assign memRdata = mem_q[ADDR];

  // Next-state logic: user accesses in IDLE, or one fill write per cycle in CLEAR.
  // Reset suppresses every write so that the memory keeps its contents.
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    doStage1_d = doStage1_q;
    memWe      = 1'b0;
    memAddr    = ADDR;
    memWdata   = DI;
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (EN) begin
            if (WE) begin
              memWe = 1'b1;
              if (WRITE_MODE == 0) begin
                doStage1_d = DI;
              end else if (WRITE_MODE == 1) begin
                doStage1_d = memRdata;
              end else begin
                doStage1_d = doStage1_q;
              end
            end else begin
              doStage1_d = memRdata;
            end
          end
          if (CLR) begin
            state_d    = CLEAR;
            clearCnt_d = '0;
          end
        end
        CLEAR: begin
          memWe      = 1'b1;
          memAddr    = clearCnt_q;
          memWdata   = INIT_FILL;
          clearCnt_d = clearCnt_q + ADDR_W'(1);
          if (clearCnt_q == '1) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Control and first output stage. A synchronous reset restores SRVAL and idles the sequencer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      clearCnt_q <= '0;
      doStage1_q <= SRVAL;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
      doStage1_q <= doStage1_d;
    end
  end

  // Memory array write port. It takes either a user write or a clear-sequencer write.
  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem_q[memAddr] <= memWdata;
    end
  end

`ifdef RAMB_SP_OUTREG_EN
  logic [DATA_W-1:0] doStage2_q;

  // Second output stage. It reloads on every edge regardless of EN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      doStage2_q <= SRVAL;
    end else begin
      doStage2_q <= doStage1_q;
    end
  end

  assign DO = doStage2_q;
`else
  assign DO = doStage1_q;
`endif

  assign BUSY = (state_q == CLEAR);

endmodule
